fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory request, and feeds the IF/ID register.
//  Handles hazard-unit stalls, downstream branch/jump redirects (including redirects while a fetch is outstanding), and halt detection.
//  Sits between the icache/memory controller and the IF/ID pipeline register.
// PARAMETERS
//  PC_INIT    32'h0000_0000  PC value after reset
//  HALT_WORD  32'hFFFF_FFFF  encoding that stops fetch
// PORTS
//  CLK           in   1   clock; all state on posedge
//  nRST          in   1   asynchronous, active-low reset
//  imemREN       out  1   instruction read request
//  imemaddr      out  32  fetch address
//  ihit          in   1   imemload valid this cycle; access complete
//  imemload      in   32  fetched instruction
//  stall         in   1   hazard unit: hold PC, no IF/ID write
//  redirect      in   1   taken branch/jump resolved downstream
//  redirect_pc   in   32  redirect target
//  ifid_writeEN  out  1   IF/ID capture enable
//  ifid_flush    out  1   IF/ID clear (squash wrong-path instr)
//  instr_out     out  32  instruction to IF/ID
//  pcplus4_out   out  32  PC+4 to IF/ID
//  halted        out  1   fetch stopped on HALT_WORD
// BEHAVIOUR
//  Reset (async, nRST=0): PC=PC_INIT, tgt=0, state=FETCH, halted=0.
//   Outputs in reset: imemREN=1, imemaddr=PC_INIT, ifid_flush=0; ifid_writeEN=0 when ihit=0.
//  Outputs:
//   imemaddr=PC always. pcplus4_out=PC+4, mod 2^32 (FFFF_FFFC wraps to 0). instr_out=imemload.
//   ifid_writeEN and ifid_flush are combinational from state and inputs; all else registered.
//   redirect_pc[1:0] forced to 0 when loaded.
//  States: FETCH, REDIRECT_WAIT, HALTED. Priority: redirect > stall > ihit.
//  FETCH:
//   imemREN=1.
//   redirect&ihit: PC<=redirect_pc; flush=1; writeEN=0; stay FETCH.
//   redirect&!ihit: tgt<=redirect_pc; flush=1; writeEN=0 -> REDIRECT_WAIT.
//    The address must stay stable until ihit; no abort.
//   stall (no redirect): PC held; writeEN=0; request stays up and is re-fetched next cycle.
//   ihit&!stall, imemload!=HALT_WORD: writeEN=1; PC<=PC+4. Single-cycle latency per hit.
//   ihit&!stall, imemload==HALT_WORD: writeEN=1 (halt flows down the pipe); PC<=PC+4 -> HALTED.
//   !ihit: hold everything; writeEN=0.
//  REDIRECT_WAIT:
//   imemREN=1; imemaddr=old PC; writeEN=0 (response is wrong-path and is discarded).
//   New redirect overwrites tgt and asserts flush=1 again.
//   ihit: PC<=tgt (or redirect_pc if redirect is asserted the same cycle) -> FETCH. stall ignored.
//  HALTED:
//   imemREN=0; halted=1; writeEN=0; PC held.
//   redirect: PC<=redirect_pc; flush=1; halted<=0 -> FETCH. This covers a halt fetched on a wrong path.
//  Reset mid-operation: any state returns to FETCH@PC_INIT immediately; a pending tgt is lost.
// STRUCTURE
//  cpu_types_pkg holds: word_t (logic[31:0]); HALT_WORD default; fetch_state_t enum {FETCH, REDIRECT_WAIT, HALTED}.
//  One sub-module, pc_reg: PC flop with async reset to PC_INIT, and load/enable.
//  The FSM and output logic are local to this module.
// TESTING
//  1 Reset, ihit=0 -> imemaddr=0, imemREN=1, ifid_writeEN=0, halted=0.
//  2 ihit=1 each cycle, stall=0 -> imemaddr 0,4,8; pcplus4_out 4,8,C; ifid_writeEN=1 every cycle.
//  3 PC=8, stall=1 with ihit for 2 cycles -> imemaddr stays 8, writeEN=0. Release -> writeEN=1, then imemaddr=C.
//  4 PC=10, ihit=0, redirect to 40 -> flush=1 for 1 cycle; imemaddr stays 10 until ihit; writeEN=0 on that ihit; next imemaddr=40.
//  5 imemload=FFFF_FFFF with ihit at PC=20 -> writeEN=1; next cycle halted=1, imemREN=0, PC=24.
//    Then redirect to 100 -> flush=1; halted=0; imemaddr=100.
//  6 redirect+stall+ihit together at PC=8, target 80 -> flush=1, writeEN=0, next imemaddr=80.
//    Also: nRST pulse while in REDIRECT_WAIT -> imemaddr=0, state FETCH.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, halt encoding, fetch FSM states.
// No logic; imported by the fetch stage and its PC register.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam word_t PC_INIT_DEF   = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        REDIRECT_WAIT = 2'd1,
        HALTED        = 2'd2
    } fetch_state_t;

    function automatic word_t align_word(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter flop: loads next_pc when en is high.
// Latency: 1 cycle. Backpressure: holds value while en is low.
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEF
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  word_t next_pc,
    output word_t pc
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= PC_INIT;
        end else if (en) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem reads, feeds IF/ID, detects halt.
// Latency: one instruction per ihit. Backpressure: stall or missing ihit holds the PC and request.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT   = PC_INIT_DEF,
    parameter word_t HALT_WORD = HALT_WORD_DEF
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  ifid_writeEN,
    output logic  ifid_flush,
    output word_t instr_out,
    output word_t pcplus4_out,
    output logic  halted
);

    fetch_state_t state;
    word_t        tgt;
    word_t        pc;
    word_t        pc_next;
    logic         pc_en;
    word_t        rpc;

    assign rpc = align_word(redirect_pc);

    pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
        .CLK     (CLK),
        .nRST    (nRST),
        .en      (pc_en),
        .next_pc (pc_next),
        .pc      (pc)
    );

    assign imemaddr    = pc;
    assign pcplus4_out = pc + 32'd4;
    assign instr_out   = imemload;
    assign imemREN     = (state != HALTED);

    // Flush is masked during reset so a redirect seen under reset cannot squash IF/ID.
    always_comb begin
        ifid_flush   = 1'b0;
        ifid_writeEN = 1'b0;
        pc_en        = 1'b0;
        pc_next      = pc;
        case (state)
            FETCH: begin
                ifid_flush = redirect & nRST;
                if (redirect) begin
                    if (ihit) begin
                        pc_en   = 1'b1;
                        pc_next = rpc;
                    end
                end else if (!stall && ihit) begin
                    ifid_writeEN = 1'b1;
                    pc_en        = 1'b1;
                    pc_next      = pc + 32'd4;
                end
            end
            REDIRECT_WAIT: begin
                ifid_flush = redirect & nRST;
                if (ihit) begin
                    pc_en   = 1'b1;
                    pc_next = redirect ? rpc : tgt;
                end
            end
            HALTED: begin
                ifid_flush = redirect & nRST;
                if (redirect) begin
                    pc_en   = 1'b1;
                    pc_next = rpc;
                end
            end
            default: begin
                ifid_flush = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= FETCH;
            tgt    <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (!ihit) begin
                            tgt   <= rpc;
                            state <= REDIRECT_WAIT;
                        end
                    end else if (!stall && ihit && imemload == HALT_WORD) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end
                end
                REDIRECT_WAIT: begin
                    if (ihit) begin
                        state <= FETCH;
                    end else if (redirect) begin
                        tgt <= rpc;
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
